fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 pc_select  input  2  next-PC choice from control_unit, sampled only on decode handshake.
REQ-005 branch_target  input  32  PC+imm for taken branch or JAL, sampled with pc_select.
REQ-006 jalr_target  input  32  rs1+imm for JALR, sampled with pc_select.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  word-aligned request address.
REQ-009 imem_gnt  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instruction  output  32  instruction presented to control_unit.
REQ-013 inst_pc  output  32  address of the presented instruction.
REQ-014 inst_valid  output  1  instruction/inst_pc valid.
REQ-015 inst_ready  input  1  decode stage consumes the instruction this cycle.
REQ-016 fetch_fault  output  1  misaligned next-PC detected; sticky.

Function
REQ-017 The FSM SHALL have exactly four states: FETCH_REQ, FETCH_WAIT, HOLD, FAULT.
REQ-018 In FETCH_REQ the block SHALL drive imem_req=1 with imem_addr=pc; on imem_gnt it SHALL go to FETCH_WAIT.
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0.
REQ-020 In FETCH_WAIT, imem_req SHALL be 0; on imem_rvalid it SHALL register imem_rdata into instruction and pc into inst_pc, then go to HOLD.
REQ-021 At most one request SHALL be outstanding; imem_rvalid outside FETCH_WAIT SHALL be ignored.
REQ-022 In HOLD, inst_valid SHALL be 1; instruction and inst_pc SHALL be stable until inst_valid && inst_ready.
REQ-023 On that handshake, next PC SHALL be: 2'b00 -> inst_pc+4; 2'b01 -> branch_target; 2'b10 -> jalr_target with bit0 cleared; 2'b11 -> inst_pc+4.
REQ-024 Addition SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000 with no fault.
REQ-025 If the computed next PC has bits[1:0]!=0, the block SHALL enter FAULT instead of FETCH_REQ.
REQ-026 FAULT SHALL be terminal until reset: fetch_fault=1, imem_req=0, inst_valid=0.
REQ-027 From the HOLD handshake, the block SHALL move to FETCH_REQ in the next cycle with pc updated; no speculative fetch.
REQ-028 Minimum latency: imem_req to inst_valid SHALL be 2 cycles when imem_gnt is immediate and imem_rvalid follows 1 cycle later.
REQ-029 inst_valid SHALL be 0 in FETCH_REQ and FETCH_WAIT.
REQ-030 Inputs pc_select, branch_target and jalr_target SHALL be ignored outside the HOLD handshake cycle.

Reset
REQ-031 On rst assertion, regardless of state or outstanding request, the block SHALL immediately go to FETCH_REQ with pc=RESET_PC.
REQ-032 Reset values SHALL be: imem_req=0 while rst is high, imem_addr=RESET_PC, instruction=32'h0000_0013 (NOP), inst_pc=RESET_PC, inst_valid=0, fetch_fault=0.
REQ-033 After rst deasserts, imem_req SHALL rise on the first clock edge-defined cycle; a response to a pre-reset request SHALL be discarded.

Structure
REQ-034 A shared package SHALL hold the pc_sel_t enum (PC_PLUS4=2'b00, PC_BRANCH=2'b01, PC_JALR=2'b10), fetch_state_t, and the NOP constant 32'h0000_0013.
REQ-035 Next-PC selection and alignment check SHALL live in one combinational sub-module, pc_next_mux; all state SHALL stay in fetch_unit.

Verification
REQ-036 Reset release, imem_gnt immediate, imem_rvalid one cycle later with 32'h0020_8193 -> imem_addr=0, then inst_valid=1, instruction=32'h0020_8193, inst_pc=0.
REQ-037 pc_select=00 handshake at inst_pc=0x100 -> next imem_addr=0x104; imem_gnt held low 3 cycles -> imem_addr stays 0x104, inst_valid=0.
REQ-038 pc_select=01, branch_target=0x40 -> next imem_addr=0x40; pc_select=10, jalr_target=0x81 -> next imem_addr=0x80.
REQ-039 inst_ready low 4 cycles in HOLD -> instruction and inst_pc unchanged; spurious imem_rvalid ignored.
REQ-040 pc_select=01, branch_target=0x42 -> fetch_fault=1, imem_req=0 permanently; then rst pulse -> fetch_fault=0 and fetch restarts at RESET_PC.
REQ-041 rst asserted in FETCH_WAIT, then imem_rvalid arrives after release -> response ignored, fresh request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its next-PC mux.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JALR   = 2'b10
   } pc_sel_t;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'b00,
      FETCH_WAIT = 2'b01,
      HOLD       = 2'b10,
      FAULT      = 2'b11
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Combinational next-PC selection plus word-alignment check; holds no state.
module pc_next_mux
   import fetch_unit_pkg::*;
(
   input  logic [1:0]  pc_select,
   input  logic [31:0] inst_pc,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   // Select the next PC; the reserved encoding 2'b11 falls through to sequential flow.
   always_comb begin
      next_pc = inst_pc + 32'd4;
      case (pc_select)
         PC_BRANCH: next_pc = branch_target;
         PC_JALR:   next_pc = {jalr_target[31:1], 1'b0};
         PC_PLUS4:  next_pc = inst_pc + 32'd4;
         default:   next_pc = inst_pc + 32'd4;
      endcase
      misaligned = pc_misaligned(next_pc);
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: request, wait for data, hold for decode,
// then redirect the PC; a misaligned redirect parks the unit in FAULT until reset.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pc_select,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fetch_fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  inst_pc_q, inst_pc_d;
   logic         imem_req_q, imem_req_d;
   logic         inst_valid_q, inst_valid_d;
   logic         fault_q, fault_d;
   logic [31:0]  next_pc;
   logic         next_misaligned;

   pc_next_mux u_pc_next_mux (
      .pc_select     (pc_select),
      .inst_pc       (inst_pc_q),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .next_pc       (next_pc),
      .misaligned    (next_misaligned)
   );

   // Next-state logic; outputs are registered from the next state so they stay glitch-free.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      inst_pc_d = inst_pc_q;
      case (state_q)
         FETCH_REQ: begin
            // imem_req_q gating keeps the first post-reset cycle from consuming a grant.
            if (imem_req_q && imem_gnt) begin
               state_d = FETCH_WAIT;
            end else begin
               state_d = FETCH_REQ;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid) begin
               instr_d   = imem_rdata;
               inst_pc_d = pc_q;
               state_d   = HOLD;
            end else begin
               state_d = FETCH_WAIT;
            end
         end
         HOLD: begin
            if (inst_valid_q && inst_ready) begin
               if (next_misaligned) begin
                  state_d = FAULT;
               end else begin
                  state_d = FETCH_REQ;
                  pc_d    = next_pc;
               end
            end else begin
               state_d = HOLD;
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
      imem_req_d   = (state_d == FETCH_REQ);
      inst_valid_d = (state_d == HOLD);
      fault_d      = (state_d == FAULT);
   end

   // State and output registers with asynchronous reset back to the first fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH_REQ;
         pc_q         <= RESET_PC;
         instr_q      <= NOP_INSTR;
         inst_pc_q    <= RESET_PC;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         inst_pc_q    <= inst_pc_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
         fault_q      <= fault_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign inst_pc     = inst_pc_q;
   assign inst_valid  = inst_valid_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/decode driver pushes expected requests and
// instructions, and an independent monitor compares them whenever the DUT presents them.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_select;
   logic [31:0] branch_target, jalr_target;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instruction, inst_pc;
   logic        inst_valid, inst_ready, fetch_fault;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_select     (pc_select),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instruction   (instruction),
      .inst_pc       (inst_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .fetch_fault   (fetch_fault)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_inst_q[$];
   logic [31:0] model_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Monitor: compare every presented request address and instruction with the scoreboard.
   initial forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0) begin
         if (imem_req === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_req: actual request at %h required no request", imem_addr);
            end else begin
               check("imem_addr", imem_addr, exp_addr_q[0]);
               if (imem_gnt) void'(exp_addr_q.pop_front());
            end
         end
         if (inst_valid === 1'b1) begin
            if (exp_inst_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: actual instr %h required inst_valid=0", instruction);
            end else begin
               logic [63:0] e;
               e = exp_inst_q[0];
               check("inst_pc", inst_pc, e[63:32]);
               check("instruction", instruction, e[31:0]);
               if (inst_ready) void'(exp_inst_q.pop_front());
            end
         end
      end
   end

   task automatic apply_reset(input bit stale_rvalid);
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
      exp_addr_q.delete();
      exp_inst_q.delete();
      exp_addr_q.push_back(RST_PC);
      model_pc = RST_PC;
      @(negedge clk);
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_imem_addr", imem_addr, RST_PC);
      check("rst_instruction", instruction, NOP);
      check("rst_inst_pc", inst_pc, RST_PC);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_fetch_fault", fetch_fault, 1'b0);
      rst = 1'b0;
      imem_rvalid = stale_rvalid;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("req_after_rst", imem_req, 1'b1);
   endtask

   task automatic serve_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data);
      int c = 0;
      while (imem_req !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      if (c >= 100) check("req_timeout", imem_req, 1'b1);
      for (int i = 0; i < gnt_dly; i++) begin
         imem_gnt = 1'b0;
         @(negedge clk);
         check("valid_in_req", inst_valid, 1'b0);
         check("req_held", imem_req, 1'b1);
      end
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      check("req_drop_in_wait", imem_req, 1'b0);
      for (int i = 0; i < rv_dly; i++) begin
         @(negedge clk);
         check("valid_in_wait", inst_valid, 1'b0);
      end
      exp_inst_q.push_back({model_pc, data});
      imem_rvalid = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata = $urandom();
   endtask

   // Hold the instruction rdy_dly cycles (optionally with stray rvalid), then hand it off.
   task automatic consume(input int rdy_dly, input logic [1:0] sel, input logic [31:0] bt,
                          input logic [31:0] jt, input bit spurious);
      logic [31:0] np;
      int c = 0;
      while (inst_valid !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      if (c >= 100) check("valid_timeout", inst_valid, 1'b1);
      for (int i = 0; i < rdy_dly; i++) begin
         inst_ready = 1'b0;
         imem_rvalid = spurious;
         imem_rdata = $urandom();
         pc_select = 2'($urandom_range(0, 3));
         branch_target = $urandom();
         jalr_target = $urandom();
         @(negedge clk);
      end
      imem_rvalid = 1'b0;
      inst_ready = 1'b1;
      pc_select = sel;
      branch_target = bt;
      jalr_target = jt;
      if (sel == 2'd1)      np = bt;
      else if (sel == 2'd2) np = jt & 32'hFFFF_FFFE;
      else                  np = model_pc + 32'd4;
      if (np % 4 == 0) begin
         model_pc = np;
         exp_addr_q.push_back(np);
      end
      @(negedge clk);
      inst_ready = 1'b0;
      pc_select = 2'($urandom_range(0, 3));
      branch_target = $urandom();
      jalr_target = $urandom();
      check("valid_after_handoff", inst_valid, 1'b0);
   endtask

   task automatic expect_fault(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         imem_gnt = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         inst_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("fault_flag", fetch_fault, 1'b1);
         check("fault_req", imem_req, 1'b0);
         check("fault_valid", inst_valid, 1'b0);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual run still active required completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      rst = 1'b1;
      pc_select = 2'b00; branch_target = 32'h0; jalr_target = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;

      // First fetch with minimum latency.
      apply_reset(1'b0);
      serve_fetch(0, 0, 32'h0020_8193);
      check("latency_valid", inst_valid, 1'b1);
      check("first_instr", instruction, 32'h0020_8193);

      // Directed redirects, stalled grant, stalled decode, wrap-around.
      consume(0, 2'b01, 32'h0000_0100, 32'h0, 1'b0);
      serve_fetch(0, 1, $urandom());
      consume(0, 2'b00, 32'h0, 32'h0, 1'b0);
      serve_fetch(3, 0, $urandom());
      consume(0, 2'b01, 32'h0000_0040, 32'h0, 1'b0);
      serve_fetch(0, 0, $urandom());
      consume(0, 2'b10, 32'h0, 32'h0000_0081, 1'b0);
      serve_fetch(1, 2, $urandom());
      consume(4, 2'b11, 32'h0000_0333, 32'h0000_0777, 1'b1);
      serve_fetch(0, 0, $urandom());
      consume(0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
      serve_fetch(0, 0, $urandom());
      consume(0, 2'b00, 32'h0, 32'h0, 1'b0);
      serve_fetch(0, 0, $urandom());
      check("wrap_no_fault", fetch_fault, 1'b0);

      // Reset while a request is outstanding; the late response must be dropped.
      consume(0, 2'b00, 32'h0, 32'h0, 1'b0);
      begin
         int c = 0;
         while (imem_req !== 1'b1 && c < 100) begin @(negedge clk); c++; end
         imem_gnt = 1'b1;
         @(negedge clk);
         imem_gnt = 1'b0;
      end
      apply_reset(1'b1);
      serve_fetch(0, 0, $urandom());

      // Randomized aligned traffic.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] bt, jt;
         bt = $urandom() & 32'hFFFF_FFFC;
         jt = $urandom() & 32'hFFFF_FFFD;
         consume($urandom_range(0, 3), 2'($urandom_range(0, 3)), bt, jt, 1'($urandom_range(0, 1)));
         serve_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
      end

      // Misaligned branch then misaligned JALR: sticky fault, cleared only by reset.
      consume(1, 2'b01, 32'h0000_0042, 32'h0, 1'b0);
      expect_fault(6);
      apply_reset(1'b0);
      serve_fetch(0, 0, $urandom());
      consume(0, 2'b10, 32'h0, 32'h0000_0083, 1'b0);
      expect_fault(4);
      apply_reset(1'b0);
      serve_fetch(0, 0, 32'h0000_0013);
      consume(0, 2'b00, 32'h0, 32'h0, 1'b0);
      check("end_no_fault", fetch_fault, 1'b0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
